// File: rtl/issue_ctrl.sv
// Issue/hazard controller between decode and id_ex: long-latency scoreboard,
// issue/stall/flush decision, post-jump flush sequencing and stall counter.
module issue_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic [4:0]       id_rd_addr_i,
  input  logic             id_reg_wen_i,
  input  logic             id_long_i,
  input  logic             ex_ready_i,
  input  logic             jump_en_i,
  input  logic             wb_valid_i,
  input  logic [4:0]       wb_rd_addr_i,
  output logic             issue_o,
  output logic             stall_o,
  output logic             flush_o,
  output logic [31:0]      busy_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic [31:0]      busy_q, busy_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [31:0] wake, set, eff_busy;
  logic        hazard;

  always_comb begin
    wake = '0;
    if (wb_valid_i && wb_rd_addr_i != 5'd0) wake[wb_rd_addr_i] = 1'b1;
  end

  // A writeback this cycle already satisfies its readers (wakeup bypass).
  assign eff_busy = busy_q & ~wake;

  assign hazard = id_valid_i &&
                  ((id_rs1_addr_i != 5'd0 && eff_busy[id_rs1_addr_i]) ||
                   (id_rs2_addr_i != 5'd0 && eff_busy[id_rs2_addr_i]) ||
                   (id_reg_wen_i && id_rd_addr_i != 5'd0 && eff_busy[id_rd_addr_i]));

  assign flush_o = jump_en_i || (state_q == FLUSH);
  assign issue_o = id_valid_i && !hazard && ex_ready_i && !flush_o;
  assign stall_o = id_valid_i && !issue_o && !flush_o;

  always_comb begin
    set = '0;
    if (issue_o && id_long_i && id_reg_wen_i && id_rd_addr_i != 5'd0)
      set[id_rd_addr_i] = 1'b1;
  end

  assign busy_d = eff_busy | set;

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (jump_en_i) begin
      fcnt_d  = FLUSH_LOAD;
      state_d = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
    end else if (state_q == FLUSH) begin
      if (fcnt_q == 4'd1) begin
        state_d = RUN;
        fcnt_d  = 4'd0;
      end else begin
        fcnt_d  = fcnt_q - 4'd1;
      end
    end else begin
      state_d = stall_o ? STALL : RUN;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      fcnt_q      <= 4'd0;
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign busy_o      = busy_q;
  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule
